// File: rtl/wb_forward_buffer_pkg.sv
// rtl/wb_forward_buffer_pkg.sv - shared pipeline types and widths for the writeback forward buffer
package wb_forward_buffer_pkg;

  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  localparam int DEPTH_DEFAULT = 4;

  // One retained writeback: valid flag, destination register and written value.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_forward_buffer_fwd_match.sv
// rtl/wb_forward_buffer_fwd_match.sv - newest-match priority search over the retained entries
module fwd_match
  import wb_forward_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         wptr,
  input  logic [REG_W-1:0]      rs,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PW-1:0] idx;

  // Walk from the oldest slot (wptr) to the newest (wptr-1); later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wptr + PW'(i);
      if (entries[idx].valid && (entries[idx].rd == rs)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_forward_buffer.sv
// rtl/wb_forward_buffer.sv - circular buffer of recent writebacks with combinational forwarding lookup
module wb_forward_buffer
  import wb_forward_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_WBEXT,
  input  logic              flush,
  input  logic              wr_en_WB,
  input  logic [REG_W-1:0]  rd_WB,
  input  logic [DATA_W-1:0] WriteData_WB,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [3:0]        count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid_q;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wptr_q;
  logic [3:0]        count_q;

  wb_entry_t [DEPTH-1:0] entries;

  logic              capture;
  logic              m_hit1, m_hit2;
  logic [DATA_W-1:0] m_data1, m_data2;

  assign capture = wr_en_WB & ~stall_WBEXT & ~flush;

  // Control state: valid bits, write pointer and occupancy; flush wins over capture and stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (capture) begin
      valid_q[wptr_q] <= 1'b1;
      wptr_q          <= wptr_q + 1'b1;
      if (count_q != 4'(DEPTH)) begin
        count_q <= count_q + 4'd1;
      end
    end
  end

  // Payload storage; a stale payload is harmless because it is only seen through its valid bit.
  always_ff @(posedge clk) begin
    if (capture) begin
      rd_q[wptr_q]   <= rd_WB;
      data_q[wptr_q] <= WriteData_WB;
    end
  end

  // Gather the slots into entry records for the search blocks.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid = valid_q[i];
      entries[i].rd    = rd_q[i];
      entries[i].data  = data_q[i];
    end
  end

  fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_match1 (
    .entries (entries),
    .wptr    (wptr_q),
    .rs      (rs1),
    .hit     (m_hit1),
    .data    (m_data1)
  );

  fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_match2 (
    .entries (entries),
    .wptr    (wptr_q),
    .rs      (rs2),
    .hit     (m_hit2),
    .data    (m_data2)
  );

  // The live WB write outranks every stored entry, regardless of stall, flush or reset.
  always_comb begin
    if (wr_en_WB && (rd_WB == rs1)) begin
      hit1  = 1'b1;
      data1 = WriteData_WB;
    end else begin
      hit1  = m_hit1;
      data1 = m_data1;
    end
    if (wr_en_WB && (rd_WB == rs2)) begin
      hit2  = 1'b1;
      data2 = WriteData_WB;
    end else begin
      hit2  = m_hit2;
      data2 = m_data2;
    end
  end

  assign count = count_q;

endmodule

// File: doc/wb_forward_buffer.md
WB_FORWARD_BUFFER -- requirements
Module: wb_forward_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of retained writeback entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port stall_WBEXT  input  1  when 1, capture is suppressed and stored state is held.
REQ-005 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-006 SHALL have port wr_en_WB  input  1  the WB-stage write is valid this cycle.
REQ-007 SHALL have port rd_WB  input  5  WB destination register.
REQ-008 SHALL have port WriteData_WB  input  32  WB write data.
REQ-009 SHALL have ports rs1, rs2  input  5 each  source registers to look up.
REQ-010 SHALL have ports hit1, hit2  output  1 each  a match was found for rs1/rs2.
REQ-011 SHALL have ports data1, data2  output  32 each  forwarded data for rs1/rs2.
REQ-012 SHALL have port count  output  4  number of valid entries, 0..DEPTH.

Function
REQ-013 SHALL store entries {valid, rd[4:0], data[31:0]} in a circular buffer of DEPTH slots, written at write pointer wptr.
REQ-014 SHALL, on a clock edge with flush=0, stall_WBEXT=0 and wr_en_WB=1, write {1, rd_WB, WriteData_WB} into slot wptr and advance wptr modulo DEPTH.
REQ-015 SHALL, when the buffer is full, overwrite the oldest entry (the slot at wptr), with count held at DEPTH.
REQ-016 SHALL increment count by 1 per capture, saturating at DEPTH.
REQ-017 SHALL leave all state unchanged when stall_WBEXT=1 or wr_en_WB=0, unless flush=1.
REQ-018 SHALL, on a clock edge with flush=1, clear every valid bit, set wptr to 0 and set count to 0; flush SHALL override a simultaneous capture and stall_WBEXT.
REQ-019 SHALL perform lookups combinationally; a lookup has zero-cycle latency.
REQ-020 SHALL give the live WB input (wr_en_WB=1 and rd_WB==rsX) highest priority, so that dataX=WriteData_WB; this SHALL apply even when stall_WBEXT=1 or flush=1.
REQ-021 SHALL otherwise select the newest valid stored entry with rd==rsX; the newest entry is the one nearest to wptr-1 going backward.
REQ-022 SHALL drive hitX=0 and dataX=0 when there is no match.
REQ-023 SHALL treat rd=0 like any other register, with no hardwired-zero filtering.
REQ-024 SHALL resolve rs1 and rs2 independently; identical rs1/rs2 SHALL yield identical results.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear all valid bits, wptr and count; rd and data storage need not be reset.
REQ-026 SHALL drive hit1=hit2=0, data1=data2=0 and count=0 during reset, except that the REQ-020 live bypass still applies.
REQ-027 SHALL abandon a capture in progress if reset is asserted mid-cycle; the first capture after release SHALL go to slot 0.

Structure
REQ-028 SHALL define the entry record type and the DEPTH default in the shared pipeline package, together with the register-index width of 5 and data width of 32.
REQ-029 SHALL implement the newest-match priority search as one sub-module, fwd_match (entries, wptr, rs -> hit, data), instantiated twice.
REQ-030 SHALL contain no storage other than the entry array, wptr and count.

Verification
REQ-031 The bench SHALL cover: reset, then capture rd=3/0x11, rd=5/0x22 -> rs1=3 gives hit1=1, data1=0x11; rs2=5 gives data2=0x22; count=2.
REQ-032 The bench SHALL cover: capture rd=7 with 0xA, then 0xB, then 0xC -> rs1=7 gives data1=0xC, because the newest entry wins.
REQ-033 The bench SHALL cover: with DEPTH=4, capture rd=1..5 with data 0x1..0x5 -> rs1=1 gives hit1=0; rs1=5 gives 0x5; count=4.
REQ-034 The bench SHALL cover: stored rd=9/0x90, stall_WBEXT=1, wr_en_WB=1, rd_WB=9, WriteData_WB=0x99 -> data1=0x99 live; after the edge and with wr_en_WB dropped, data1=0x90 and count is unchanged.
REQ-035 The bench SHALL cover: flush=1 together with a capture of rd=2/0x2 -> next cycle hit1=hit2=0 for rs=2 and count=0; the next capture lands in slot 0.
REQ-036 The bench SHALL cover: rst_n asserted asynchronously between edges with 3 entries stored -> count=0 and hits=0 immediately, without waiting for a clock edge.
